// File: rtl/raster_pkg.sv
// raster_pkg: types and helpers shared by the 2D-shape raster engines
// (circle, line, rectangle).
//   state_t      - circle engine FSM states
//   MODE_OUTLINE - draw only the circle outline
//   MODE_FILL    - draw a filled disc as horizontal spans
//   clip_coord() - 1 when a signed coordinate falls outside [0, lim)
package raster_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PLOT  = 3'd2,
        SPAN  = 3'd3,
        STEP  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic MODE_OUTLINE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

    // Coordinates are evaluated wide and signed, so a point left of or
    // above the screen is rejected here instead of wrapping to the far edge.
    function automatic logic clip_coord(input int v, input int lim);
        return (v < 0) || (v >= lim);
    endfunction

endpackage

// File: rtl/span_walker.sv
// span_walker: emits the pixels of one horizontal span x0..x1 on row y.
//   clk, rst      - clock, synchronous active-high reset
//   abort_i       - drops the span and any pending pixel at once
//   load_i        - starts a new span; only pulsed while the walker is idle
//   x0_i, x1_i    - signed span end points, clamped here to [0, SCR_W-1]
//   y_i           - signed row; an off-screen row yields an empty span
//   ready_i       - consumer ready
//   valid_o       - pixel on px_o/py_o is valid
//   px_o, py_o    - pixel coordinate
//   span_done_o   - span finished: every pixel issued and the last one
//                   accepted in this cycle (or none was ever pending)
module span_walker
    import raster_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int SCR_W   = 256,
    parameter int SCR_H   = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort_i,
    input  logic                load_i,
    input  logic signed [31:0]  x0_i,
    input  logic signed [31:0]  x1_i,
    input  logic signed [31:0]  y_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [COORD_W-1:0]  px_o,
    output logic [COORD_W-1:0]  py_o,
    output logic                span_done_o
);

    logic               valid_q;
    logic               act_q;     // pixels still to issue
    logic               busy_q;    // span loaded and not yet finished
    logic [COORD_W-1:0] cur_q;
    logic [COORD_W-1:0] end_q;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;

    int   lo;
    int   hi;
    logic empty;
    logic stall;

    always_comb begin
        lo    = (x0_i < 0) ? 0 : x0_i;
        hi    = (x1_i >= SCR_W) ? SCR_W - 1 : x1_i;
        // lo > hi also covers spans lying wholly left or right of the screen
        empty = clip_coord(y_i, SCR_H) || (lo > hi);
        stall = valid_q && !ready_i;
    end

    assign span_done_o = busy_q && !act_q && !stall;
    assign valid_o     = valid_q;
    assign px_o        = px_q;
    assign py_o        = py_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            cur_q   <= '0;
            end_q   <= '0;
            row_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
        end else if (abort_i) begin
            valid_q <= 1'b0;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            if (span_done_o) begin
                busy_q <= 1'b0;
            end
            if (load_i) begin
                busy_q <= 1'b1;
                act_q  <= !empty;
                cur_q  <= COORD_W'(lo);
                end_q  <= COORD_W'(hi);
                row_q  <= COORD_W'(y_i);
            end else if (act_q && !stall) begin
                valid_q <= 1'b1;
                px_q    <= cur_q;
                py_q    <= row_q;
                if (cur_q == end_q) begin
                    act_q <= 1'b0;
                end else begin
                    cur_q <= cur_q + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/circle_raster.sv
// circle_raster: midpoint (Bresenham) circle rasteriser, outline or filled.
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - job request (taken in IDLE) / cancel active job
//   xc, yc, r           - centre and radius, sampled on accept
//   fill_enable, color  - mode and colour, sampled on accept
//   busy, done          - job active / one-cycle completion pulse
//   pixel_valid/ready   - pixel stream handshake
//   px, py, pixel_color - pixel data
//   pix_count           - pixels accepted in the current/last job (saturating)
//   dbg_state           - current FSM state
//
// Pixel handshake: a pixel transfers on a cycle with pixel_valid && pixel_ready.
// While pixel_valid is high and pixel_ready low, px/py/pixel_color hold and
// the engine stalls; pixel_valid only falls after a transfer, abort or rst.
module circle_raster
    import raster_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 24,
    parameter int SCR_W   = 256,
    parameter int SCR_H   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] xc,
    input  logic [COORD_W-1:0] yc,
    input  logic [COORD_W-1:0] r,
    input  logic               fill_enable,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic [COLOR_W-1:0] pixel_color,
    output logic [15:0]        pix_count,
    output state_t             dbg_state
);

    localparam int CW = COORD_W + 2;       // candidate / x,y width
    localparam int DW = 2 * COORD_W + 4;   // decision variable width

    state_t                state_q;
    logic                  mode_q;
    logic [COORD_W-1:0]    xc_q, yc_q, r_q;
    logic [COLOR_W-1:0]    col_q;
    logic signed [CW-1:0]  x_q, y_q;
    logic signed [DW-1:0]  d_q;
    logic [2:0]            oct_q;          // outline candidate index
    logic [1:0]            sp_q;           // fill span index
    logic                  wait_q;         // waiting for span_walker
    logic                  busy_q, done_q, pv_q;
    logic [COORD_W-1:0]    ppx_q, ppy_q;
    logic [15:0]           cnt_q;

    int                    xi, yi, di, xci, yci;
    int                    cx, cy;
    logic                  keep, plot_hit, plot_stall;
    int                    sp_row, sp_lo, sp_hi;
    logic                  sp_apply;
    logic signed [CW-1:0]  x_d, y_d;
    logic signed [DW-1:0]  d_d;

    logic                  w_load, w_valid, w_done;
    logic [COORD_W-1:0]    w_px, w_py;

    always_comb begin
        xi  = int'(x_q);
        yi  = int'(y_q);
        di  = int'(d_q);
        xci = int'(xc_q);
        yci = int'(yc_q);

        // Eight octant reflections of (x, y)
        cx = xci;
        cy = yci;
        case (oct_q)
            3'd0: begin cx = xci + xi; cy = yci + yi; end
            3'd1: begin cx = xci - xi; cy = yci + yi; end
            3'd2: begin cx = xci + xi; cy = yci - yi; end
            3'd3: begin cx = xci - xi; cy = yci - yi; end
            3'd4: begin cx = xci + yi; cy = yci + xi; end
            3'd5: begin cx = xci - yi; cy = yci + xi; end
            3'd6: begin cx = xci + yi; cy = yci - xi; end
            default: begin cx = xci - yi; cy = yci - xi; end
        endcase

        // Reflections coincide on the axes (x==0) and diagonals (x==y);
        // keep only the first copy of each. x==y==0 is the r==0 centre.
        if (xi == 0 && yi == 0) begin
            keep = (oct_q == 3'd0);
        end else if (xi == 0) begin
            keep = (oct_q == 3'd0) || (oct_q == 3'd2) || (oct_q == 3'd4) || (oct_q == 3'd5);
        end else if (xi == yi) begin
            keep = !oct_q[2];
        end else begin
            keep = 1'b1;
        end
        plot_hit   = keep && !clip_coord(cx, SCR_W) && !clip_coord(cy, SCR_H);
        plot_stall = pv_q && !pixel_ready;

        // Rows yc+-x are drawn every step; rows yc+-y only on the step
        // before y decrements, so every row is drawn exactly once.
        sp_row   = yci + xi;
        sp_lo    = xci - yi;
        sp_hi    = xci + yi;
        sp_apply = 1'b1;
        case (sp_q)
            2'd0: ;
            2'd1: begin sp_row = yci - xi; sp_apply = (xi != 0); end
            2'd2: begin
                sp_row   = yci + yi;
                sp_lo    = xci - xi;
                sp_hi    = xci + xi;
                sp_apply = (di > 0) && (xi < yi);
            end
            default: begin
                sp_row   = yci - yi;
                sp_lo    = xci - xi;
                sp_hi    = xci + xi;
                sp_apply = (di > 0) && (xi < yi);
            end
        endcase

        x_d = x_q + CW'(1);
        y_d = (di > 0) ? y_q - CW'(1) : y_q;
        d_d = (di <= 0) ? DW'(di + 4 * xi + 6) : DW'(di + 4 * (xi - yi) + 10);

        w_load = (state_q == SPAN) && !wait_q && sp_apply;
    end

    span_walker #(
        .COORD_W (COORD_W),
        .SCR_W   (SCR_W),
        .SCR_H   (SCR_H)
    ) u_span (
        .clk         (clk),
        .rst         (rst),
        .abort_i     (abort && (state_q != IDLE)),
        .load_i      (w_load),
        .x0_i        (sp_lo),
        .x1_i        (sp_hi),
        .y_i         (sp_row),
        .ready_i     (pixel_ready),
        .valid_o     (w_valid),
        .px_o        (w_px),
        .py_o        (w_py),
        .span_done_o (w_done)
    );

    assign pixel_valid = (mode_q == MODE_FILL) ? w_valid : pv_q;
    assign px          = (mode_q == MODE_FILL) ? w_px : ppx_q;
    assign py          = (mode_q == MODE_FILL) ? w_py : ppy_q;
    assign pixel_color = col_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pix_count   = cnt_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_OUTLINE;
            xc_q    <= '0;
            yc_q    <= '0;
            r_q     <= '0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            oct_q   <= '0;
            sp_q    <= '0;
            wait_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
            ppx_q   <= '0;
            ppy_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (pixel_valid && pixel_ready && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (pv_q && pixel_ready) begin
                pv_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= fill_enable;
                        xc_q    <= xc;
                        yc_q    <= yc;
                        r_q     <= r;
                        col_q   <= color;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    x_q     <= '0;
                    y_q     <= CW'(r_q);
                    d_q     <= DW'(3 - 2 * int'(r_q));
                    oct_q   <= '0;
                    sp_q    <= '0;
                    wait_q  <= 1'b0;
                    state_q <= (mode_q == MODE_FILL) ? SPAN : PLOT;
                end
                PLOT: begin
                    if (!plot_stall) begin
                        pv_q <= plot_hit;
                        if (plot_hit) begin
                            ppx_q <= COORD_W'(cx);
                            ppy_q <= COORD_W'(cy);
                        end
                        oct_q <= oct_q + 3'd1;
                        if (oct_q == 3'd7) begin
                            state_q <= STEP;
                        end
                    end
                end
                SPAN: begin
                    if (!wait_q) begin
                        if (sp_apply) begin
                            wait_q <= 1'b1;
                        end else begin
                            sp_q <= sp_q + 2'd1;
                            if (sp_q == 2'd3) state_q <= STEP;
                        end
                    end else if (w_done) begin
                        wait_q <= 1'b0;
                        sp_q   <= sp_q + 2'd1;
                        if (sp_q == 2'd3) state_q <= STEP;
                    end
                end
                STEP: begin
                    // Waits for the last outline pixel so done follows it.
                    if (!plot_stall) begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        d_q    <= d_d;
                        oct_q  <= '0;
                        sp_q   <= '0;
                        wait_q <= 1'b0;
                        if (x_d > y_d) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= (mode_q == MODE_FILL) ? SPAN : PLOT;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                pv_q    <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_circle_raster.sv
module tb_circle_raster;
  import raster_pkg::*;

  localparam int SCR_W = 256;
  localparam int SCR_H = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  xc, yc, r;
  logic        fill_enable;
  logic [23:0] color;
  logic        busy, done, pixel_valid, pixel_ready;
  logic [7:0]  px, py;
  logic [23:0] pixel_color;
  logic [15:0] pix_count;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  circle_raster #(
    .COORD_W(8), .COLOR_W(24), .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .xc(xc), .yc(yc), .r(r), .fill_enable(fill_enable), .color(color),
    .busy(busy), .done(done), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .px(px), .py(py), .pixel_color(pixel_color), .pix_count(pix_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: pixel set of one job, built from the circle rules
  task automatic add_span(input int row, input int lo, input int hi);
    if (row < 0 || row >= SCR_H) return;
    for (int p = lo; p <= hi; p++)
      if (p >= 0 && p < SCR_W) exp_q.push_back({8'(p), 8'(row)});
  endtask

  task automatic build_model(input int cx0, input int cy0, input int rr, input bit fill);
    int x, y, d, qx, qy, key;
    int ox[8];
    int oy[8];
    int step_keys[$];
    int hits[$];
    exp_q.delete();
    x = 0; y = rr; d = 3 - 2 * rr;
    while (x <= y) begin
      if (!fill) begin
        ox = '{x, -x, x, -x, y, -y, y, -y};
        oy = '{y, y, -y, -y, x, x, -x, -x};
        step_keys.delete();
        for (int k = 0; k < 8; k++) begin
          qx = cx0 + ox[k];
          qy = cy0 + oy[k];
          key = (qx + 1024) * 4096 + (qy + 1024);
          hits = step_keys.find_first_index(e) with (e == key);
          if (hits.size() == 0) begin
            step_keys.push_back(key);
            if (qx >= 0 && qx < SCR_W && qy >= 0 && qy < SCR_H)
              exp_q.push_back({8'(qx), 8'(qy)});
          end
        end
      end else begin
        add_span(cy0 + x, cx0 - y, cx0 + y);
        if (x != 0) add_span(cy0 - x, cx0 - y, cx0 + y);
        if (d > 0 && x < y) begin
          add_span(cy0 + y, cx0 - x, cx0 + x);
          add_span(cy0 - y, cx0 - x, cx0 + x);
        end
      end
      if (d <= 0) d = d + 4 * x + 6;
      else begin
        d = d + 4 * (x - y) + 10;
        y = y - 1;
      end
      x = x + 1;
    end
  endtask

  // driver + scoreboard for one job
  task automatic run_job(input int jxc, input int jyc, input int jr, input bit jfill,
                         input bit rnd, input int abort_at, input int hold, input bit wrap_chk);
    logic [23:0] jcol;
    logic [15:0] key;
    logic [7:0]  s_px, s_py;
    logic [23:0] s_col;
    bit          seen[logic [15:0]];
    int          idx[$];
    int          exp_n, accepted, n_done;
    bit          prev_stall, finished, aborted, rdy;
    jcol = 24'($urandom);
    build_model(jxc, jyc, jr, jfill);
    exp_n = exp_q.size();
    accepted = 0; n_done = 0;
    prev_stall = 0; finished = 0; aborted = 0;
    s_px = '0; s_py = '0; s_col = '0;

    @(negedge clk);
    xc = 8'(jxc); yc = 8'(jyc); r = 8'(jr);
    fill_enable = jfill; color = jcol; start = 1'b1; pixel_ready = 1'b1;
    @(negedge clk);
    check_eq("busy_after_accept", 32'(busy), 1);
    check_eq("count_cleared", 32'(pix_count), 0);

    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      start = (cyc < hold);
      if (prev_stall) begin
        check_eq("hold_valid", 32'(pixel_valid), 1);
        check_eq("hold_px", 32'(px), 32'(s_px));
        check_eq("hold_py", 32'(py), 32'(s_py));
        check_eq("hold_color", 32'(pixel_color), 32'(s_col));
      end
      if (done) begin
        n_done++;
        finished = 1;
      end else if (abort_at != 0 && accepted == abort_at) begin
        abort = 1'b1;
        pixel_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_valid", 32'(pixel_valid), 0);
        check_eq("abort_count", 32'(pix_count), 32'(abort_at));
        aborted = 1;
        finished = 1;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pixel_ready = rdy;
        if (pixel_valid && rdy) begin
          key = {px, py};
          idx = exp_q.find_first_index(e) with (e == key);
          check_eq("pixel_expected", idx.size(), 1);
          if (idx.size() > 0) exp_q.delete(idx[0]);
          check_eq("pixel_unique", 32'(seen.exists(key)), 0);
          seen[key] = 1;
          check_eq("pixel_color", 32'(pixel_color), 32'(jcol));
          if (wrap_chk) check_eq("no_wrap", 32'(px >= 8'd250 || py >= 8'd250), 0);
          accepted++;
        end
        prev_stall = pixel_valid && !rdy;
        s_px = px; s_py = py; s_col = pixel_color;
        @(negedge clk);
      end
    end

    start = 1'b0;
    pixel_ready = 1'b1;
    if (!finished) check_eq("job_timeout", 0, 1);
    if (aborted) begin
      repeat (10) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check_eq("abort_no_done", n_done, 0);
      check_eq("abort_idle", 32'(dbg_state), 32'(IDLE));
    end else if (finished) begin
      check_eq("done_pulse", n_done, 1);
      check_eq("pix_count", 32'(pix_count), 32'(exp_n));
      check_eq("missing_pixels", exp_q.size(), 0);
      @(negedge clk);
      check_eq("done_one_cycle", 32'(done), 0);
      check_eq("busy_after_done", 32'(busy), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_valid"}, 32'(pixel_valid), 0);
    check_eq({tag, "_px"}, 32'(px), 0);
    check_eq({tag, "_py"}, 32'(py), 0);
    check_eq({tag, "_color"}, 32'(pixel_color), 0);
    check_eq({tag, "_count"}, 32'(pix_count), 0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pixel_ready = 1'b1;
    xc = '0; yc = '0; r = '0; fill_enable = 1'b0; color = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // abort while idle is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 0);
    check_eq("idle_abort_state", 32'(dbg_state), 32'(IDLE));

    run_job(100, 100, 5, 1'b0, 1'b0, 0, 0, 1'b0);   // outline r=5
    run_job(50, 50, 3, 1'b1, 1'b0, 0, 0, 1'b0);     // fill r=3
    run_job(2, 2, 5, 1'b0, 1'b0, 0, 0, 1'b1);       // outline clipped near origin
    run_job(120, 80, 10, 1'b1, 1'b1, 0, 0, 1'b0);   // fill r=10, random ready
    run_job(100, 100, 20, 1'b0, 1'b0, 7, 0, 1'b0);  // abort after 7 pixels
    run_job(10, 10, 0, 1'b0, 1'b0, 0, 5, 1'b0);     // r=0, start held while busy
    run_job(250, 3, 10, 1'b1, 1'b1, 0, 0, 1'b0);    // fill clamped at right/top

    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, 0, 1'b0);

    // reset in the middle of a fill job
    @(negedge clk);
    xc = 8'd128; yc = 8'd128; r = 8'd8; fill_enable = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("midjob_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midjob_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
